// File: rtl/mmac_matmul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mmac_matmul_seq_pkg
//   Shared types and default sizing for the sequential matrix MAC engine.
//   - mmac_state_t : controller states (IDLE, LOAD, COMPUTE, DRAIN)
//   - DEF_N / DEF_DATA_WIDTH / DEF_ACC_WIDTH : default matrix size and widths
// -----------------------------------------------------------------------------
package mmac_matmul_seq_pkg;

    localparam int DEF_N          = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + $clog2(DEF_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } mmac_state_t;

endpackage

// File: rtl/mmac_matmul_seq_if.sv
// -----------------------------------------------------------------------------
// mmac_matmul_seq_if
//   Operand stream (in_*), result stream (out_*) and job control/status of the
//   matrix MAC engine.
//   master : producer/consumer side (drives operands, clear, acc_en, out_ready)
//   slave  : engine side (drives in_ready, out_*, busy, done)
// -----------------------------------------------------------------------------
interface mmac_matmul_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 18
);
    logic                  clear;
    logic                  acc_en;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_data;
    logic                  out_last;
    logic                  out_ovf;
    logic                  busy;
    logic                  done;

    modport master (
        output clear, acc_en, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ovf, busy, done
    );

    modport slave (
        input  clear, acc_en, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ovf, busy, done
    );
endinterface

// File: rtl/mmac_matmul_seq_pe.sv
// -----------------------------------------------------------------------------
// mmac_matmul_seq_pe
//   Single combinational multiply-accumulate: sum = seed + a*b.
//   Ports: seed (running sum in), a/b (unsigned operands),
//          sum (updated running sum), ovf (this addition clamped).
//   Macro MMAC_SATURATE_EN: clamp at 2^ACC_WIDTH-1 and flag ovf;
//   otherwise the sum wraps and ovf is 0.
// -----------------------------------------------------------------------------
module mmac_matmul_seq_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 18
) (
    input  logic [ACC_WIDTH-1:0]  seed,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  ovf
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;

    assign prod     = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    assign prod_ext = ACC_WIDTH'(prod);

`ifdef MMAC_SATURATE_EN
    // Returns {clamped, sum}; the extra carry bit decides the clamp.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] x,
                                                   input logic [ACC_WIDTH-1:0] y);
        logic [ACC_WIDTH:0] full;
        full = {1'b0, x} + {1'b0, y};
        if (full[ACC_WIDTH])
            return {1'b1, {ACC_WIDTH{1'b1}}};
        return full;
    endfunction

    assign {ovf, sum} = sat_add(seed, prod_ext);
`else
    function automatic logic [ACC_WIDTH-1:0] wrap_add(input logic [ACC_WIDTH-1:0] x,
                                                      input logic [ACC_WIDTH-1:0] y);
        return x + y;
    endfunction

    assign sum = wrap_add(seed, prod_ext);
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mmac_matmul_seq.sv
// -----------------------------------------------------------------------------
// mmac_matmul_seq
//   Sequential N x N matrix multiply(-accumulate) C = A*B or C += A*B on one
//   time-multiplexed MAC. Operands stream in row-major, are buffered, the
//   product is formed over N^3 MAC cycles, and C drains row-major with
//   backpressure. C persists across jobs until clear or reset.
//   Ports: clk, rst (async, active-high), bus (mmac_matmul_seq_if.slave).
//   Macro MMAC_SATURATE_EN: saturating sums with per-element ovf stored in C
//   and presented on out_ovf; undefined -> wrap-around, out_ovf = 0.
// -----------------------------------------------------------------------------
module mmac_matmul_seq
    import mmac_matmul_seq_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    mmac_matmul_seq_if.slave bus
);

    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int CW    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [CW-1:0]    LAST_RC  = CW'(N - 1);

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
        $error("mmac_matmul_seq: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    function automatic logic [IDX_W-1:0] rc_idx(input logic [CW-1:0] r,
                                                 input logic [CW-1:0] c);
        return IDX_W'(r) * IDX_W'(N) + IDX_W'(c);
    endfunction

    mmac_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] a_mem [NN];
    logic [DATA_WIDTH-1:0] b_mem [NN];
    logic [ACC_WIDTH-1:0]  c_mem [NN];
`ifdef MMAC_SATURATE_EN
    logic [NN-1:0]         ovf_mem;
`endif

    logic [IDX_W-1:0]     load_idx, drain_idx;
    logic [CW-1:0]        ci, cj, ck;
    logic                 acc_q;
    logic                 in_ready, out_valid, in_hs, out_hs;
    logic                 mac_en, k_first, k_last, ij_last;
    logic [IDX_W-1:0]     ij_idx;
    logic [ACC_WIDTH-1:0] seed, pe_sum;
    logic                 pe_ovf, seed_ovf, run_ovf;
    logic [ACC_WIDTH-1:0] sum_p1;
    logic                 ovf_p1, wb_vld_p1, last_p1;
    logic [IDX_W-1:0]     wb_addr_p1;
    logic                 done_q;

    // Controller: next state and handshake enables
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid && load_idx == LAST_IDX) state_d = COMPUTE;
            end
            COMPUTE: begin
                // leave only once the final element's write-back has issued
                if (last_p1) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (bus.out_ready && drain_idx == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_hs  = bus.in_valid && in_ready;
    assign out_hs = out_valid && bus.out_ready;

    // Stage p0: operand fetch and MAC for (i, j, k)
    assign mac_en  = (state_q == COMPUTE) && !last_p1;
    assign k_first = (ck == '0);
    assign k_last  = (ck == LAST_RC);
    assign ij_last = (ci == LAST_RC) && (cj == LAST_RC);
    assign ij_idx  = rc_idx(ci, cj);
    assign seed    = k_first ? (acc_q ? c_mem[ij_idx] : '0) : sum_p1;

`ifdef MMAC_SATURATE_EN
    assign seed_ovf = k_first ? (acc_q & ovf_mem[ij_idx]) : ovf_p1;
`else
    assign seed_ovf = k_first ? 1'b0 : ovf_p1;
`endif
    assign run_ovf = seed_ovf | pe_ovf;

    mmac_matmul_seq_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_pe (
        .seed (seed),
        .a    (a_mem[rc_idx(ci, ck)]),
        .b    (b_mem[rc_idx(ck, cj)]),
        .sum  (pe_sum),
        .ovf  (pe_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_idx   <= '0;
            drain_idx  <= '0;
            ci         <= '0;
            cj         <= '0;
            ck         <= '0;
            acc_q      <= 1'b0;
            sum_p1     <= '0;
            ovf_p1     <= 1'b0;
            wb_vld_p1  <= 1'b0;
            wb_addr_p1 <= '0;
            last_p1    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= out_hs && (drain_idx == LAST_IDX);

            if (state_q == IDLE && in_hs)
                acc_q <= bus.acc_en;
            if (in_hs)
                load_idx <= (load_idx == LAST_IDX) ? '0 : load_idx + IDX_W'(1);
            if (out_hs)
                drain_idx <= (drain_idx == LAST_IDX) ? '0 : drain_idx + IDX_W'(1);

            // Stage p1: running sum register and C write-back request
            wb_vld_p1 <= mac_en && k_last;
            last_p1   <= mac_en && k_last && ij_last;
            if (mac_en) begin
                sum_p1     <= pe_sum;
                ovf_p1     <= run_ovf;
                wb_addr_p1 <= ij_idx;
                ck <= k_last ? '0 : ck + CW'(1);
                if (k_last) begin
                    cj <= (cj == LAST_RC) ? '0 : cj + CW'(1);
                    if (cj == LAST_RC)
                        ci <= (ci == LAST_RC) ? '0 : ci + CW'(1);
                end
            end
        end
    end

    // Operand buffers and the persistent C store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NN; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
                c_mem[n] <= '0;
            end
`ifdef MMAC_SATURATE_EN
            ovf_mem <= '0;
`endif
        end else begin
            if (in_hs) begin
                a_mem[load_idx] <= bus.in_a;
                b_mem[load_idx] <= bus.in_b;
            end
            if (state_q == IDLE && bus.clear) begin
                for (int n = 0; n < NN; n++)
                    c_mem[n] <= '0;
`ifdef MMAC_SATURATE_EN
                ovf_mem <= '0;
`endif
            end else if (wb_vld_p1) begin
                c_mem[wb_addr_p1] <= sum_p1;
`ifdef MMAC_SATURATE_EN
                ovf_mem[wb_addr_p1] <= ovf_p1;
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? c_mem[drain_idx] : '0;
    assign bus.out_last  = out_valid && (drain_idx == LAST_IDX);
`ifdef MMAC_SATURATE_EN
    assign bus.out_ovf   = out_valid && ovf_mem[drain_idx];
`else
    assign bus.out_ovf   = 1'b0;
`endif
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mmac_matmul_seq.sv
// -----------------------------------------------------------------------------
// tb_mmac_matmul_seq
//   Scoreboard bench for mmac_matmul_seq. Three engines share clk/rst:
//   u_dut2 (N=2, default ACC), u_dutw (N=2, ACC_WIDTH=16), u_dut4 (N=4).
//   Expected result beats are queued when a job is issued; per-engine
//   monitors pop and compare on every output handshake.
//   Macro MMAC_SATURATE_EN selects the clamped expectations for u_dutw.
// -----------------------------------------------------------------------------
module tb_mmac_matmul_seq;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmac_matmul_seq_if #(.DATA_WIDTH(8), .ACC_WIDTH(17)) b2 ();
    mmac_matmul_seq_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) bw ();
    mmac_matmul_seq_if #(.DATA_WIDTH(8), .ACC_WIDTH(18)) b4 ();

    mmac_matmul_seq #(.N(2), .DATA_WIDTH(8)) u_dut2 (
        .clk (clk), .rst (rst), .bus (b2.slave));
    mmac_matmul_seq #(.N(2), .DATA_WIDTH(8), .ACC_WIDTH(16)) u_dutw (
        .clk (clk), .rst (rst), .bus (bw.slave));
    mmac_matmul_seq #(.N(4), .DATA_WIDTH(8)) u_dut4 (
        .clk (clk), .rst (rst), .bus (b4.slave));

    typedef struct {
        longint data;
        bit     last;
        bit     ovf;
    } exp_t;

    exp_t q2[$];
    exp_t qw[$];
    exp_t q4[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_total++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic push(input int sel, input longint d, input bit l, input bit o);
        exp_t e;
        e.data = d; e.last = l; e.ovf = o;
        case (sel)
            0: q2.push_back(e);
            1: qw.push_back(e);
            default: q4.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0: return q2.size();
            1: return qw.size();
            default: return q4.size();
        endcase
    endfunction

    task automatic mon(input int sel, input string tag, input longint data,
                       input bit last, input bit ovf);
        exp_t e;
        bit   got = 1'b0;
        case (sel)
            0: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            1: if (qw.size() > 0) begin e = qw.pop_front(); got = 1'b1; end
            default: if (q4.size() > 0) begin e = q4.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            fail_now({tag, "_extra_beat"}, $sformatf("beat data %0d with nothing expected", data));
        end else begin
            check({tag, "_data"}, data, e.data);
            check({tag, "_last"}, longint'(last), longint'(e.last));
            check({tag, "_ovf"}, longint'(ovf), longint'(e.ovf));
        end
    endtask

    always @(negedge clk)
        if (rst === 1'b0 && b2.out_valid === 1'b1 && b2.out_ready === 1'b1)
            mon(0, "n2", longint'(b2.out_data), b2.out_last, b2.out_ovf);
    always @(negedge clk)
        if (rst === 1'b0 && bw.out_valid === 1'b1 && bw.out_ready === 1'b1)
            mon(1, "w16", longint'(bw.out_data), bw.out_last, bw.out_ovf);
    always @(negedge clk)
        if (rst === 1'b0 && b4.out_valid === 1'b1 && b4.out_ready === 1'b1)
            mon(2, "n4", longint'(b4.out_data), b4.out_last, b4.out_ovf);

    task automatic set_in(input int sel, input bit v, input int a, input int b,
                          input bit acc, input bit clr);
        case (sel)
            0: begin b2.in_valid = v; b2.in_a = 8'(a); b2.in_b = 8'(b); b2.acc_en = acc; b2.clear = clr; end
            1: begin bw.in_valid = v; bw.in_a = 8'(a); bw.in_b = 8'(b); bw.acc_en = acc; bw.clear = clr; end
            default: begin b4.in_valid = v; b4.in_a = 8'(a); b4.in_b = 8'(b); b4.acc_en = acc; b4.clear = clr; end
        endcase
    endtask

    // which: 0 out_valid, 1 done, 2 busy, 3 in_ready
    function automatic bit get_sig(input int sel, input int which);
        logic [3:0] s;
        case (sel)
            0: s = {b2.in_ready, b2.busy, b2.done, b2.out_valid};
            1: s = {bw.in_ready, bw.busy, bw.done, bw.out_valid};
            default: s = {b4.in_ready, b4.busy, b4.done, b4.out_valid};
        endcase
        return s[which];
    endfunction

    // Called just after a rising edge; returns just after the edge that
    // took the last beat, with that edge's cycle number in t_last.
    task automatic load(input int sel, input int n, input int a[16], input int b[16],
                        input bit acc, input bit clr, input bit gaps, output int t_last);
        for (int idx = 0; idx < n * n; idx++) begin
            if (gaps && (idx % 2 == 1)) begin
                set_in(sel, 1'b0, 0, 0, acc, 1'b0);
                repeat (2) @(posedge clk);
                #1;
            end
            set_in(sel, 1'b1, a[idx], b[idx], acc, clr && (idx == 0));
            @(posedge clk);
            #1;
        end
        t_last = cyc;
        set_in(sel, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic push_job(input int sel, input int r[16], input int n_el, input bit o);
        for (int idx = 0; idx < n_el; idx++)
            push(sel, longint'(r[idx]), idx == n_el - 1, o);
    endtask

    task automatic wait_valid(input int sel, input string tag, output int t);
        bit seen = 1'b0;
        t = 0;
        for (int w = 0; w < 400 && !seen; w++) begin
            @(negedge clk);
            if (get_sig(sel, 0)) begin seen = 1'b1; t = cyc; end
        end
        if (!seen) fail_now({tag, "_valid"}, "timeout waiting for out_valid");
    endtask

    task automatic wait_done(input int sel, input string tag);
        bit seen = 1'b0;
        for (int w = 0; w < 400 && !seen; w++) begin
            @(negedge clk);
            if (get_sig(sel, 1)) seen = 1'b1;
        end
        if (!seen) begin
            fail_now({tag, "_done"}, "timeout waiting for done");
        end else begin
            check({tag, "_busy_at_done"}, longint'(get_sig(sel, 2)), 0);
            check({tag, "_beats_left"}, longint'(qsize(sel)), 0);
            @(negedge clk);
            check({tag, "_done_pulse"}, longint'(get_sig(sel, 1)), 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int A[16]  = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int B[16]  = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int R1[16] = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int R2[16] = '{38, 44, 86, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int F[16]  = '{255, 255, 255, 255, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef MMAC_SATURATE_EN
    int RW[16] = '{65535, 65535, 65535, 65535, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit OW = 1'b1;
`else
    int RW[16] = '{64514, 64514, 64514, 64514, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit OW = 1'b0;
`endif
    int ID[16] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int SEQ[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};

    initial begin
        int t_last, t_valid;
        rst = 1'b1;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 0, 0, 1'b0, 1'b0);
        b2.out_ready = 1'b1;
        bw.out_ready = 1'b1;
        b4.out_ready = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_in_ready", longint'(b2.in_ready), 1);
        check("rst_out_valid", longint'(b2.out_valid), 0);
        check("rst_out_data", longint'(b2.out_data), 0);
        check("rst_out_last", longint'(b2.out_last), 0);
        check("rst_out_ovf", longint'(b2.out_ovf), 0);
        check("rst_busy", longint'(b2.busy), 0);
        check("rst_done", longint'(b2.done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // plain product
        push_job(0, R1, 4, 1'b0);
        load(0, 2, A, B, 1'b0, 1'b0, 1'b0, t_last);
        wait_done(0, "job_mul");

        // accumulate on top of the previous C
        push_job(0, R2, 4, 1'b0);
        load(0, 2, A, B, 1'b1, 1'b0, 1'b0, t_last);
        wait_done(0, "job_acc");

        // clear with the first beat, accumulate onto zeros
        push_job(0, R1, 4, 1'b0);
        load(0, 2, A, B, 1'b1, 1'b1, 1'b0, t_last);
        wait_done(0, "job_clear");

        // input gaps during LOAD, output stall after the first beat
        push_job(0, R1, 4, 1'b0);
        load(0, 2, A, B, 1'b0, 1'b0, 1'b1, t_last);
        wait_valid(0, "stall", t_valid);
        @(posedge clk);
        #1;
        b2.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_hold_data", longint'(b2.out_data), 22);
            check("stall_hold_valid", longint'(b2.out_valid), 1);
            check("stall_hold_last", longint'(b2.out_last), 0);
        end
        @(posedge clk);
        #1;
        b2.out_ready = 1'b1;
        wait_done(0, "job_stall");

        // reset in the middle of COMPUTE discards the job and C
        load(0, 2, A, B, 1'b0, 1'b0, 1'b0, t_last);
        @(negedge clk);
        check("compute_busy", longint'(b2.busy), 1);
        check("compute_in_ready", longint'(b2.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", longint'(b2.busy), 0);
        check("midrst_in_ready", longint'(b2.in_ready), 1);
        check("midrst_out_valid", longint'(b2.out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_job(0, R1, 4, 1'b0);
        load(0, 2, A, B, 1'b1, 1'b0, 1'b0, t_last);
        wait_done(0, "job_after_rst");

        // 16-bit accumulator with every element at 255
        push_job(1, RW, 4, OW);
        load(1, 2, F, F, 1'b0, 1'b0, 1'b0, t_last);
        wait_done(1, "job_w16");

        // N=4 identity times 1..16, with result latency
        push_job(2, SEQ, 16, 1'b0);
        load(2, 4, ID, SEQ, 1'b0, 1'b0, 1'b0, t_last);
        wait_valid(2, "n4", t_valid);
        check("n4_first_valid_latency", longint'(t_valid - t_last), 65);
        wait_done(2, "job_n4");

        check("n2_queue_empty", longint'(q2.size()), 0);
        check("w16_queue_empty", longint'(qw.size()), 0);
        check("n4_queue_empty", longint'(q4.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmac_matmul_seq.md
# mmac_matmul_seq

Sequential, parametrised N×N matrix multiply-accumulate engine: C = A·B (or C = C + A·B), built on a single time-multiplexed MAC. Operands arrive as a valid/ready element stream, are buffered, multiplied over N³ cycles, then drained as a result stream with backpressure. It is the next generation of the single-accumulator MAC unit, sitting between the operand fetch stream and the result writeback in the mmac datapath.

## Interface
- N, 4, matrix dimension (N ≥ 2)
- DATA_WIDTH, 8, unsigned operand element width
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N), result element width; elaboration error if < 2*DATA_WIDTH
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  sync; zeroes stored C, honoured only in IDLE
- acc_en  in  1  sampled on first accepted input beat; 1 = C += A·B, 0 = C = A·B
- in_valid  in  1  operand beat valid
- in_ready  out  1  high in IDLE and LOAD
- in_a  in  DATA_WIDTH  element A[r][c], row-major
- in_b  in  DATA_WIDTH  element B[r][c], row-major, same beat index as in_a
- out_valid  out  1  result beat valid (DRAIN only)
- out_ready  in  1  consumer accepts beat
- out_data  out  ACC_WIDTH  element C[r][c], row-major
- out_last  out  1  high with beat N*N-1
- out_ovf  out  1  element clamped (see Configuration)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after last output handshake

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN. Reset: IDLE, all counters 0, A/B/C buffers 0; in_ready=1, out_valid=0, out_data=0, out_last=0, out_ovf=0, busy=0, done=0.
- IDLE→LOAD on first in_valid&&in_ready (beat 0 stored, acc_en latched). LOAD counts accepted beats; after beat N*N-1 → COMPUTE. Gaps in in_valid stall LOAD indefinitely.
- COMPUTE: counters i,j,k, k innermost. Per cycle sum += A[i][k]*B[k][j]. k==0 seeds sum with (acc_latched ? C[i][j] : 0). At k==N-1 result written to C[i][j]. After (i,j,k)=(N-1,N-1,N-1) → DRAIN.
- Arithmetic: product 2*DATA_WIDTH unsigned, zero-extended to ACC_WIDTH; sum wraps modulo 2^ACC_WIDTH by default.
- DRAIN: out_data = C[idx], idx advances only on out_valid&&out_ready; out_data/out_last stable while stalled. After handshake on idx N*N-1 → IDLE, done=1 that cycle-next.
- clear in IDLE together with first input beat: C zeroed and beat accepted; accumulate then sees zeros. clear outside IDLE ignored.
- Inputs ignored (in_ready=0) during COMPUTE and DRAIN. C persists across jobs until clear or reset.
- reset asserted mid-operation: immediate return to IDLE state above; partial job discarded.

## Timing
- COMPUTE entered the cycle after the last input handshake; lasts exactly N³ cycles.
- out_valid rises N³+1 cycles after the last input handshake edge.
- Minimum job: N² (load) + N³ (compute) + N² (drain) cycles + 1 IDLE cycle before next load.
- done pulses 1 cycle, coincident with return to IDLE.

## Configuration
- MMAC_SATURATE_EN defined: running sum clamps at 2^ACC_WIDTH-1; per-element ovf bit stored, driven on out_ovf with its element; ovf bits cleared with C.
- Undefined: wrap-around arithmetic, no ovf storage, out_ovf tied 0.

## Structure
- mmac_pkg: add mmac_state_t enum (IDLE, LOAD, COMPUTE, DRAIN), default N/ACC_WIDTH constants alongside existing DATA_WIDTH.
- Sub-module mmac_pe: one MAC (seed, multiply, add, wrap/saturate, ovf out), combinational; top owns buffers, counters and FSM.

## Test plan
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], acc_en=0 -> out [19,22,43,50], out_last on 4th beat, done one pulse.
- Repeat same job with acc_en=1 -> [38,44,86,100]; then clear in IDLE + acc_en=1 job -> [19,22,43,50].
- N=2, ACC_WIDTH=16, all elements 255 -> without macro each 64514, out_ovf=0; with MMAC_SATURATE_EN each 65535, out_ovf=1.
- out_ready low 3 cycles after first output beat -> out_data holds 22, no beats lost or duplicated; in_valid gaps during LOAD -> same result.
- N=4, A=identity, B=1..16 -> out 1..16; first out_valid exactly 65 cycles after last input handshake.
- reset pulsed mid-COMPUTE -> next cycle busy=0, in_ready=1, out_valid=0; following acc_en=1 job returns plain A·B.
